// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl
//    Scan sequencer wrapped around an external 16-to-1 mux. A Start in IDLE
//    latches the channel mask. The block then steps the registered select S16
//    through each enabled channel in ascending order. At each channel it waits
//    SETTLE extra cycles and then samples the mux output f. When the last
//    enabled channel has been sampled, the assembled word is published on Q and
//    Done pulses for one cycle.
//
//    Parameter
//       SETTLE  extra wait cycles per channel before sampling f (0..7)
//    Ports
//       Clock   in   rising-edge clock
//       Resetn  in   asynchronous active-low reset
//       Start   in   scan request, accepted only in IDLE
//       Mask    in   [0:15] channel enables, latched on accept
//       f       in   mux output
//       S16     out  registered mux select
//       Q       out  [0:15] result word, Q[i] is f sampled while S16 == i
//       Busy    out  high in SCAN and DONE
//       Done    out  one-cycle pulse on the cycle Q is updated
//       Valid   out  Q holds a completed scan
//
//    state    | meaning
//    ---------+-------------------------------------------------------------
//    ST_IDLE  | waiting for Start; S16 parked at 0
//    ST_SCAN  | counting settle cycles / sampling f on the current channel
//    ST_DONE  | single cycle: Q just updated, Done and Busy high

module mux16_scan_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   input  logic [0:15] Mask,
   input  logic        f,
   output logic [3:0]  S16,
   output logic [0:15] Q,
   output logic        Busy,
   output logic        Done,
   output logic        Valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [2:0] SETTLE_C = 3'(SETTLE);

   state_e      state_q, state_d;
   logic [0:15] mask_q,  mask_d;
   logic [0:15] cap_q,   cap_d;
   logic [0:15] q_q,     q_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic [3:0]  sel_q,   sel_d;
   logic        valid_q, valid_d;

   // Lowest enabled channel of the incoming mask (used on accept).
   logic [3:0]  first_ch;
   // Lowest enabled channel of the latched mask strictly above the current select.
   logic [3:0]  next_ch;
   logic        next_found;

   always_comb begin
      first_ch = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (Mask[i]) begin
            first_ch = 4'(i);
         end
      end
   end

   always_comb begin
      next_ch    = 4'd0;
      next_found = 1'b0;
      // Descending walk so the last hit is the lowest qualifying channel;
      // channels at or below the current select never qualify, so no wrap.
      for (int i = 15; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(sel_q))) begin
            next_ch    = 4'(i);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cap_d   = cap_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      valid_d = valid_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               mask_d  = Mask;
               cap_d   = '0;
               valid_d = 1'b0;
               if (|Mask) begin
                  sel_d   = first_ch;
                  cnt_d   = SETTLE_C;
                  state_d = ST_SCAN;
               end else begin
                  // Empty scan completes at once; Valid must read 1 in DONE.
                  q_d     = '0;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_SCAN: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               cap_d[sel_q] = f;
               if (next_found) begin
                  sel_d = next_ch;
                  cnt_d = SETTLE_C;
               end else begin
                  // Publish including the sample taken on this edge.
                  q_d     = cap_d;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            sel_d   = 4'd0;
            state_d = ST_IDLE;
         end

         default: begin
            sel_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         cap_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
      end
   end

   assign S16   = sel_q;
   assign Q     = q_q;
   assign Busy  = (state_q != ST_IDLE);
   assign Done  = (state_q == ST_DONE);
   assign Valid = valid_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: two instances (SETTLE=1 and SETTLE=0) share the
// stimulus, each driving its own copy of a behavioural 16-to-1 mux over the
// data word w_r. Each cycle's expected outputs are derived from the scan rules:
// the ascending list of enabled channels, N*(SETTLE+1) latency, and Q = data & mask.

module tb_mux16_scan_ctrl;

   logic        clk_sys;
   logic        clk_en;
   logic        rst_n;
   logic        start_r;
   logic [0:15] mask_r;
   logic [0:15] w_r;

   logic        f1, f0;
   logic [3:0]  s16_1, s16_0;
   logic [0:15] q_1, q_0;
   logic        busy_1, busy_0, done_1, done_0, valid_1, valid_0;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [0:15] pq1, pq0;

   assign f1 = w_r[s16_1];
   assign f0 = w_r[s16_0];

   mux16_scan_ctrl #(.SETTLE(1)) u_dut1 (
      .Clock (clk_sys), .Resetn(rst_n), .Start(start_r), .Mask(mask_r), .f(f1),
      .S16   (s16_1),   .Q     (q_1),   .Busy (busy_1),  .Done(done_1), .Valid(valid_1)
   );

   mux16_scan_ctrl #(.SETTLE(0)) u_dut0 (
      .Clock (clk_sys), .Resetn(rst_n), .Start(start_r), .Mask(mask_r), .f(f0),
      .S16   (s16_0),   .Q     (q_0),   .Busy (busy_0),  .Done(done_0), .Valid(valid_0)
   );

   always #5 if (clk_en) clk_sys = ~clk_sys;

   wire [31:0] obs1 = {5'd0, s16_1, busy_1, done_1, valid_1, q_1};
   wire [31:0] obs0 = {5'd0, s16_0, busy_0, done_0, valid_0, q_0};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected {S16, Busy, Done, Valid, Q} in the cycle starting k edges after accept.
   function automatic logic [31:0] exp_vec(input int s, input logic [0:15] m,
                                           input logic [0:15] w, input logic [0:15] pq,
                                           input int k);
      int n;
      int lat;
      int ch[$];
      logic [3:0] last;
      for (int i = 0; i < 16; i++) if (m[i]) ch.push_back(i);
      n    = ch.size();
      lat  = n * (s + 1);
      last = (n > 0) ? 4'(ch[n-1]) : 4'd0;
      if (k < lat)       return {5'd0, 4'(ch[k / (s + 1)]), 3'b100, pq};
      else if (k == lat) return {5'd0, last, 3'b111, w & m};
      else               return {5'd0, 4'd0, 3'b001, w & m};
   endfunction

   // One scan; while both instances are busy, Start is re-pulsed randomly and
   // Mask scrambled every cycle, all of which must be ignored.
   task automatic run_scan(input logic [0:15] m, input logic [0:15] w, input string name);
      int n, l1, l0;
      n  = $countones(m);
      l1 = n * 2;
      l0 = n;
      @(negedge clk_sys);
      w_r     = w;
      mask_r  = m;
      start_r = 1'b1;
      @(posedge clk_sys);
      for (int k = 0; k <= l1 + 1; k++) begin
         @(negedge clk_sys);
         check_eq($sformatf("%s settle1 k%0d", name, k), obs1, exp_vec(1, m, w, pq1, k));
         check_eq($sformatf("%s settle0 k%0d", name, k), obs0, exp_vec(0, m, w, pq0, k));
         start_r = (k + 1 <= l0 + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         mask_r  = 16'($urandom);
      end
      start_r = 1'b0;
      pq1 = w & m;
      pq0 = w & m;
   endtask

   task automatic reset_mid_scan();
      logic [0:15] w;
      w = 16'($urandom);
      @(negedge clk_sys);
      w_r     = w;
      mask_r  = 16'hFFFF;
      start_r = 1'b1;
      @(posedge clk_sys);
      for (int k = 0; k <= 14; k++) begin
         @(negedge clk_sys);
         start_r = 1'b0;
      end
      check_eq("midscan select", {28'd0, s16_1}, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midscan reset settle1", obs1, 32'd0);
      check_eq("midscan reset settle0", obs0, 32'd0);
      #1 rst_n = 1'b1;
      pq1 = '0;
      pq0 = '0;
   endtask

   initial begin
      logic [0:15] m;
      clk_sys = 1'b0;
      clk_en  = 1'b0;
      rst_n   = 1'b1;
      start_r = 1'b0;
      mask_r  = '0;
      w_r     = '0;
      pq1     = '0;
      pq0     = '0;

      #1 rst_n = 1'b0;
      #2;
      check_eq("reset no clock settle1", obs1, 32'd0);
      check_eq("reset no clock settle0", obs0, 32'd0);
      #3 clk_en = 1'b1;
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;

      run_scan(16'hFFFF, 16'hA5C3, "full_a5c3");
      run_scan(16'h8001, 16'hFFFF, "ends_only");
      run_scan(16'h0000, 16'($urandom), "empty");
      reset_mid_scan();
      run_scan(16'hFFFF, 16'hA5C3, "after_reset");

      for (int r = 0; r < 20; r++) begin
         case ($urandom_range(0, 3))
            0:       m = 16'($urandom) & 16'($urandom);
            1:       m = 16'h8000 >> $urandom_range(0, 15);
            2:       m = (r % 2 == 0) ? 16'h0000 : 16'h0001;
            default: m = 16'($urandom);
         endcase
         run_scan(m, 16'($urandom), $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
